// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: reads bytes from an upstream FIFO and packs them into LANES-wide words.
//   Optional feature macro: FIFO_RD_PACKER_PARITY_EN adds out_par (per-lane XOR parity).
//   Ports:
//     clk         rising-edge clock
//     rst         asynchronous active-low reset
//     fifo_empty  upstream FIFO empty flag
//     fifo_data   upstream read data, valid one cycle after fifo_rd
//     fifo_rd     read strobe to the upstream FIFO (combinational)
//     flush       single-cycle pulse: emit the partial word
//     out_data    packed word, first byte read in bits [DW-1:0]
//     out_bytes   number of valid lanes in out_data
//     out_valid   out_data/out_bytes valid
//     out_ready   downstream accepts when high with out_valid
//     out_par     (parity build only) bit i = XOR of lane i of out_data
module fifo_rd_packer #(
    parameter int DW    = 8,
    parameter int LANES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fifo_empty,
    input  logic [DW-1:0]       fifo_data,
    output logic                fifo_rd,
    input  logic                flush,
    output logic [DW*LANES-1:0] out_data,
    output logic [3:0]          out_bytes,
    output logic                out_valid,
    input  logic                out_ready
`ifdef FIFO_RD_PACKER_PARITY_EN
    ,output logic [LANES-1:0]   out_par
`endif
);
    localparam int         IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [3:0] LN = 4'(LANES);

    typedef enum logic {FILL, OUT} state_t;

    state_t                      state;
    logic [3:0]                  req_cnt;
    logic [3:0]                  cap_cnt;
    logic                        rd_q;
    logic                        flush_pend;
    logic [LANES-1:0][DW-1:0]    lanes;
    logic                        last;

    // Reads are strictly one-cycle latency, so req_cnt == cap_cnt + rd_q always holds.
    assign fifo_rd   = (state == FILL) && !fifo_empty && (req_cnt < LN) && !flush_pend && rst;
    assign last      = rd_q && (cap_cnt == LN - 4'd1);
    assign out_data  = lanes;
    assign out_valid = (state == OUT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FILL;
            req_cnt    <= '0;
            cap_cnt    <= '0;
            rd_q       <= 1'b0;
            flush_pend <= 1'b0;
            lanes      <= '0;
            out_bytes  <= '0;
        end else begin
            rd_q <= fifo_rd;
            if (fifo_rd)
                req_cnt <= req_cnt + 4'd1;
            if (rd_q) begin
                lanes[cap_cnt[IW-1:0]] <= fifo_data;
                cap_cnt                <= cap_cnt + 4'd1;
            end
            if (state == FILL) begin
                // A completing word wins over any flush arriving with its last byte.
                if (last) begin
                    state     <= OUT;
                    out_bytes <= LN;
                end else if (flush_pend && !rd_q) begin
                    state     <= OUT;
                    out_bytes <= cap_cnt;
                end else if (flush && (rd_q || (cap_cnt != 4'd0 && fifo_rd))) begin
                    // A read is in flight (or being issued): wait for its byte first.
                    flush_pend <= 1'b1;
                end else if (flush && cap_cnt != 4'd0) begin
                    state     <= OUT;
                    out_bytes <= cap_cnt;
                end
            end else if (out_ready) begin
                state      <= FILL;
                req_cnt    <= '0;
                cap_cnt    <= '0;
                flush_pend <= 1'b0;
                lanes      <= '0;
                out_bytes  <= '0;
            end
        end
    end

`ifdef FIFO_RD_PACKER_PARITY_EN
    genvar i;
    for (i = 0; i < LANES; i++) begin : g_par
        assign out_par[i] = ^lanes[i];
    end
`endif
endmodule
